ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//  EX/MEM pipeline register of the 5-stage MIPS core; consumes the ID_EX outputs plus the EX ALU results.
//  Resolves BEQ/BNE and the destination register (Rt/Rd/$31), then registers everything for the MEM stage.
//  Issues a one-shot branch-redirect pulse to the front end and keeps a saturating taken-branch counter.
// PARAMETERS
//  N         32            data/address width
//  RESET_PC  32'h0040_0000 reset value of PC4_EX_MEM and BranchTarget_EX_MEM
//  CNT_W     16            width of BranchCount
// PORTS
//  clk                  in   1   clock; all state updates on falling edge (matches other pipeline regs)
//  reset                in   1   synchronous, active-low reset, sampled on the falling clk edge
//  Enable_EX_MEM        in   1   1 = capture new inputs; 0 = hold (MEM stall)
//  Flush_EX_MEM         in   1   1 = load a bubble at next edge
//  Valid_ID_EX          in   1   incoming slot holds a real instruction
//  PC4_ID_EX            in   N   PC+4 of the instruction in EX
//  ALUResult            in   N   EX ALU result
//  Zero                 in   1   ALU zero flag
//  ReadData2_ID_EX      in   N   store data
//  SignExtend_ID_EX     in   N   sign-extended immediate
//  Rt_ID_EX, Rd_ID_EX   in   5   register specifiers
//  RegDest_ID_EX, JAL_ID_EX, BEQ_ID_EX, BNE_ID_EX        in 1  EX controls
//  MEMWrite_ID_EX, MEMRead_ID_EX, RegWrite_ID_EX, MemToReg_ID_EX  in 1  MEM/WB controls
//  ALUResult_EX_MEM     out  N   registered ALU result / memory address
//  WriteData_EX_MEM     out  N   registered store data
//  WriteReg_EX_MEM      out  5   registered destination register
//  PC4_EX_MEM           out  N   registered PC+4 (link value for JAL)
//  MEMWrite_EX_MEM, MEMRead_EX_MEM, RegWrite_EX_MEM, MemToReg_EX_MEM, JAL_EX_MEM  out 1
//  Valid_EX_MEM         out  1   slot holds a real instruction
//  BranchTaken          out  1   one-cycle redirect/flush pulse to IF_ID and ID_EX
//  BranchTarget_EX_MEM  out  N   redirect address, valid while BranchTaken=1
//  BranchCount          out  CNT_W  saturating count of taken branches
// BEHAVIOUR
//  - Reset (reset=0 at edge): PC4_EX_MEM = BranchTarget_EX_MEM = RESET_PC; every other output and state bit = 0.
//  - Priority at each edge: reset > Flush_EX_MEM > Enable_EX_MEM=1 (capture) > hold.
//  - Flush: Valid and all MEM/WB controls and JAL cleared; data fields may hold; Flush overrides Enable=0.
//  - Capture, latency 1 edge. WriteReg mux: JAL ? 31 : RegDest ? Rd : Rt.
//    RegWrite_EX_MEM = RegWrite & Valid & (WriteReg!=0); JAL forces RegWrite=1 when Valid.
//    MEMWrite & MEMRead both set: MEMWrite kept, MEMRead cleared. Valid_ID_EX=0: all controls captured as 0.
//  - Branch: take = Valid & ((BEQ & Zero) | (BNE & ~Zero)). BEQ & BNE both set: BEQ wins.
//    target = PC4_ID_EX + (SignExtend_ID_EX << 2), modulo 2^N, shifted-out bits dropped.
//  - BranchTaken FSM: IDLE -> PULSE on a capture with take=1 (BranchTarget loaded at that edge);
//    PULSE -> SENT at the next edge if Enable=0, else -> IDLE, or -> PULSE if that edge captures another take.
//    SENT -> IDLE on the next capture or flush. BranchTaken=1 only in PULSE, so a held branch never re-flushes.
//  - Flush or reset while in PULSE/SENT: -> IDLE, BranchTaken drops at that edge.
//  - BranchCount += 1 on each IDLE/SENT->PULSE transition; saturates at 2^CNT_W-1; cleared by reset only.
//  - Hold (Enable=0, no flush): all registers and BranchCount unchanged.
// TESTING
//  1 reset=0 for 2 edges -> PC4_EX_MEM=0x0040_0000, Valid=0, BranchTaken=0, BranchCount=0.
//  2 capture lw: RegDest=0, Rt=8, ALUResult=0x1001_0004, MEMRead=1, RegWrite=1
//    -> after 1 edge WriteReg=8, MEMRead=1, ALUResult_EX_MEM=0x1001_0004.
//  3 BEQ, Zero=1, PC4=0x0040_0010, imm=0xFFFF_FFFE -> BranchTaken=1 for 1 cycle, target 0x0040_0008, count=1.
//  4 as 3, then Enable=0 for 3 cycles -> BranchTaken high only on first cycle, outputs held, count stays 1.
//  5 JAL, PC4=0x0040_0020 -> WriteReg=31, RegWrite=1, PC4_EX_MEM=0x0040_0020; RegDest=1, Rd=0 -> RegWrite=0.
//  6 Flush=1 with Enable=0 during valid sw -> Valid=0, MEMWrite=0; count at 0xFFFF plus one taken -> stays 0xFFFF.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves BEQ/BNE and the destination register, registers EX results for MEM.
// Latency: 1 falling clk edge from ID_EX inputs to *_EX_MEM outputs; BranchTaken is a one-cycle pulse.
// Backpressure: Enable_EX_MEM=0 holds every register (MEM stall); Flush_EX_MEM loads a bubble and wins over hold.
//
// Ports:
//   clk, reset (sync, active-low)           - all state updates on the falling clk edge
//   Enable_EX_MEM, Flush_EX_MEM             - capture / bubble controls
//   *_ID_EX, ALUResult, Zero                - instruction slot coming out of EX
//   *_EX_MEM                                - registered slot for the MEM stage
//   BranchTaken, BranchTarget_EX_MEM        - redirect pulse and address to the front end
//   BranchCount                             - saturating count of taken branches
module ex_mem_stage #(
  parameter int              N        = 32,
  parameter logic [N-1:0]    RESET_PC = 32'h0040_0000,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Enable_EX_MEM,
  input  logic             Flush_EX_MEM,
  input  logic             Valid_ID_EX,
  input  logic [N-1:0]     PC4_ID_EX,
  input  logic [N-1:0]     ALUResult,
  input  logic             Zero,
  input  logic [N-1:0]     ReadData2_ID_EX,
  input  logic [N-1:0]     SignExtend_ID_EX,
  input  logic [4:0]       Rt_ID_EX,
  input  logic [4:0]       Rd_ID_EX,
  input  logic             RegDest_ID_EX,
  input  logic             JAL_ID_EX,
  input  logic             BEQ_ID_EX,
  input  logic             BNE_ID_EX,
  input  logic             MEMWrite_ID_EX,
  input  logic             MEMRead_ID_EX,
  input  logic             RegWrite_ID_EX,
  input  logic             MemToReg_ID_EX,
  output logic [N-1:0]     ALUResult_EX_MEM,
  output logic [N-1:0]     WriteData_EX_MEM,
  output logic [4:0]       WriteReg_EX_MEM,
  output logic [N-1:0]     PC4_EX_MEM,
  output logic             MEMWrite_EX_MEM,
  output logic             MEMRead_EX_MEM,
  output logic             RegWrite_EX_MEM,
  output logic             MemToReg_EX_MEM,
  output logic             JAL_EX_MEM,
  output logic             Valid_EX_MEM,
  output logic             BranchTaken,
  output logic [N-1:0]     BranchTarget_EX_MEM,
  output logic [CNT_W-1:0] BranchCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    SENT  = 2'd2
  } br_state_t;

  br_state_t      state, state_nxt;
  logic [4:0]     wreg_sel;
  logic           take;
  logic [N-1:0]   target;
  logic           cnt_inc;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Destination mux and branch resolution; BEQ takes precedence when both flags are set.
  always_comb begin
    wreg_sel = JAL_ID_EX ? 5'd31 : (RegDest_ID_EX ? Rd_ID_EX : Rt_ID_EX);
    take     = Valid_ID_EX & (BEQ_ID_EX ? Zero : (BNE_ID_EX & ~Zero));
    target   = PC4_ID_EX + (SignExtend_ID_EX << 2);
  end

  always_ff @(negedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A held branch moves PULSE->SENT so the redirect is issued exactly once;
  // only entries into PULSE from IDLE/SENT are counted.
  always_comb begin
    state_nxt = state;
    if (Flush_EX_MEM)
      state_nxt = IDLE;
    else if (Enable_EX_MEM)
      state_nxt = take ? PULSE : IDLE;
    else if (state == PULSE)
      state_nxt = SENT;
    cnt_inc     = (state_nxt == PULSE) && (state != PULSE);
    BranchTaken = (state == PULSE);
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      ALUResult_EX_MEM    <= '0;
      WriteData_EX_MEM    <= '0;
      WriteReg_EX_MEM     <= '0;
      PC4_EX_MEM          <= RESET_PC;
      BranchTarget_EX_MEM <= RESET_PC;
      MEMWrite_EX_MEM     <= 1'b0;
      MEMRead_EX_MEM      <= 1'b0;
      RegWrite_EX_MEM     <= 1'b0;
      MemToReg_EX_MEM     <= 1'b0;
      JAL_EX_MEM          <= 1'b0;
      Valid_EX_MEM        <= 1'b0;
      BranchCount         <= '0;
    end else if (Flush_EX_MEM) begin
      // Data fields are left as they are; only the slot's effects are killed.
      MEMWrite_EX_MEM <= 1'b0;
      MEMRead_EX_MEM  <= 1'b0;
      RegWrite_EX_MEM <= 1'b0;
      MemToReg_EX_MEM <= 1'b0;
      JAL_EX_MEM      <= 1'b0;
      Valid_EX_MEM    <= 1'b0;
    end else if (Enable_EX_MEM) begin
      ALUResult_EX_MEM <= ALUResult;
      WriteData_EX_MEM <= ReadData2_ID_EX;
      WriteReg_EX_MEM  <= wreg_sel;
      PC4_EX_MEM       <= PC4_ID_EX;
      Valid_EX_MEM     <= Valid_ID_EX;
      // A store wins over a simultaneous load request.
      MEMWrite_EX_MEM  <= Valid_ID_EX & MEMWrite_ID_EX;
      MEMRead_EX_MEM   <= Valid_ID_EX & MEMRead_ID_EX & ~MEMWrite_ID_EX;
      // JAL always links into $31; writes to $0 are suppressed.
      RegWrite_EX_MEM  <= Valid_ID_EX & (JAL_ID_EX | (RegWrite_ID_EX & (wreg_sel != 5'd0)));
      MemToReg_EX_MEM  <= Valid_ID_EX & MemToReg_ID_EX;
      JAL_EX_MEM       <= Valid_ID_EX & JAL_ID_EX;
      if (take)
        BranchTarget_EX_MEM <= target;
      if (cnt_inc && (BranchCount != CNT_MAX))
        BranchCount <= BranchCount + CNT_ONE;
    end
  end

endmodule
